disp_arbiter: RTL and testbench

Round-robin arbiter that shares the 32-bit seven-segment display word (`data_seg`, consumed by the `seven` dynamic-display block) among `NREQ` requesters: the RISC-V core plus debug/status sources. Each grant latches the winner's word and holds it for a fixed dwell time so the display is readable. It then re-arbitrates. It sits between the requesters and `seven` in `top`, replacing the direct core→`seven` connection.

---
 rtl/disp_arbiter_if.sv | 24 ++
 rtl/disp_arbiter.sv | 94 +++++++++
 tb/tb_disp_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/disp_arbiter_if.sv
// Requester/display bundle for disp_arbiter: request lines, packed words, ack and display outputs.
interface disp_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = $clog2(NREQ)
);
  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] data_in;
  logic [NREQ-1:0]    ack;
  logic [31:0]        data_seg;
  logic [IW-1:0]      owner;
  logic               busy;

  // Requester side
  modport master (
    output req, data_in,
    input  ack, data_seg, owner, busy
  );

  // Arbiter side
  modport slave (
    input  req, data_in,
    output ack, data_seg, owner, busy
  );
endinterface

// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing the seven-segment display word among NREQ sources.
// Each grant latches the winner's word and holds it for DWELL cycles before re-arbitrating.
module disp_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DWELL = 100000
) (
  input logic          clk,
  input logic          rst,
  disp_arbiter_if.slave bus
);
  localparam int unsigned IW      = $clog2(NREQ);
  localparam logic [31:0] CntInit = 32'(DWELL - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [31:0]     data_seg_q, data_seg_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic            found;
  logic [IW-1:0]   gnt_idx;
  int              idx;

  // Round-robin search starting just after the last winner, wrapping modulo NREQ
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = (int'(ptr_q) + k) % int'(NREQ);
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  // Next-state: grant in IDLE, count down the dwell in HOLD (requests ignored there)
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    data_seg_d = data_seg_q;
    ack_d      = '0;
    case (state_q)
      StIdle: begin
        if (found) begin
          data_seg_d     = bus.data_in[32*gnt_idx +: 32];
          owner_d        = gnt_idx;
          ptr_d          = gnt_idx;
          ack_d[gnt_idx] = 1'b1;
          cnt_d          = CntInit;
          state_d        = StHold;
        end
      end
      StHold: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 32'd1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; pointer resets to NREQ-1 so source 0 wins first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ptr_q      <= IW'(NREQ - 1);
      owner_q    <= '0;
      data_seg_q <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      data_seg_q <= data_seg_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.data_seg = data_seg_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = (state_q == StHold);
endmodule

// File: tb/tb_disp_arbiter.sv
// Scoreboard bench for disp_arbiter with NREQ=2, DWELL=4.
module tb_disp_arbiter;
  logic clk;
  logic rst;

  disp_arbiter_if #(.NREQ(2)) bus ();

  disp_arbiter #(
    .NREQ (2),
    .DWELL(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] word;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic [31:0] word);
    exp_t e;
    e.idx  = idx;
    e.word = word;
    q.push_back(e);
  endtask

  // Monitor: every ack pulse must match the oldest expected grant
  always @(negedge clk) begin
    if (rst && bus.ack != 2'b00) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got %b expected none at %0t", bus.ack, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("mon_ack", 32'(bus.ack), 32'(2'b01 << e.idx));
        check("mon_owner", 32'(bus.owner), 32'(e.idx));
        check("mon_data", bus.data_seg, e.word);
        check("mon_busy", 32'(bus.busy), 32'd1);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [1:0] exp_ack;

    // Reset held with requests pending
    rst          = 1'b0;
    bus.req      = 2'b11;
    bus.data_in  = {32'h0000_BBBB, 32'h0000_AAAA};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_data", bus.data_seg, 32'h0);
      check("rst_ack", 32'(bus.ack), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_owner", 32'(bus.owner), 32'h0);
    end
    bus.req = 2'b00;
    @(posedge clk);
    #1 rst = 1'b1;

    // Single request from source 1
    bus.data_in[63:32] = 32'h0000_1234;
    bus.req            = 2'b10;
    push(1, 32'h0000_1234);
    @(posedge clk);
    #1 bus.req = 2'b00;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
    end
    check("single_busy_cycles", 32'(n), 32'd4);
    check("single_data_idle", bus.data_seg, 32'h0000_1234);
    check("single_ack_idle", 32'(bus.ack), 32'h0);
    check("single_owner", 32'(bus.owner), 32'd1);

    // Contention: grants alternate 0,1,0,1 at edges 1,6,11,16
    bus.data_in = {32'h0000_BBBB, 32'h0000_AAAA};
    bus.req     = 2'b11;
    push(0, 32'h0000_AAAA);
    push(1, 32'h0000_BBBB);
    push(0, 32'h0000_AAAA);
    push(1, 32'h0000_BBBB);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_ack = (k % 5 == 1) ? (((k / 5) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check("cont_ack", 32'(bus.ack), 32'(exp_ack));
    end
    bus.req = 2'b00;
    repeat (3) @(negedge clk);

    // Late request for source 1 during source 0's hold; source 0's word changes mid-hold
    bus.data_in[31:0] = 32'h0000_AAAA;
    bus.req           = 2'b01;
    push(0, 32'h0000_AAAA);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("late_ack0", 32'(bus.ack), 32'h1);
        bus.req           = 2'b00;
        bus.data_in[31:0] = 32'h0000_5555;
      end else if (k <= 4) begin
        check("late_no_ack", 32'(bus.ack), 32'h0);
        check("stable_hold_data", bus.data_seg, 32'h0000_AAAA);
        check("late_busy", 32'(bus.busy), (k == 4) ? 32'h0 : 32'h1);
        if (k == 1) begin
          bus.req            = 2'b10;
          bus.data_in[63:32] = 32'h0000_CCCC;
          push(1, 32'h0000_CCCC);
        end
      end else begin
        check("late_ack1", 32'(bus.ack), 32'h2);
        check("late_data", bus.data_seg, 32'h0000_CCCC);
        bus.req = 2'b00;
      end
    end
    repeat (6) @(negedge clk);

    // Reset mid-hold of source 0, then priority restarts at source 0
    bus.data_in[31:0] = 32'h0000_AAAA;
    bus.req           = 2'b01;
    push(0, 32'h0000_AAAA);
    @(posedge clk);
    #1 bus.req = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_data", bus.data_seg, 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_ack", 32'(bus.ack), 32'h0);
    check("midrst_owner", 32'(bus.owner), 32'h0);
    bus.req = 2'b11;
    push(0, 32'h0000_AAAA);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 bus.req = 2'b00;
    repeat (8) @(negedge clk);

    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
